trace_uart_tx: RTL
==================

// Module: trace_uart_tx
// PURPOSE
//  Debug-trace consumer placed downstream of the processor top. Snapshots the four
//  observation buses (PC, ALU result, r0, r31) plus write_condition on each capture strobe,
//  buffers snapshots in a small FIFO and serialises each one as an 18-byte UART frame.
//  Lets the board stream the execution trace to a host without stalling the core.
// PARAMETERS
//  CLK_DIV     434  clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
//  FIFO_DEPTH  4    snapshot entries; power of two, 2..16
// PORTS
//  clock        in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  capture      in   1   sample inputs this cycle (tie high = trace every instruction)
//  pc_in        in   32  current instruction address
//  alu_in       in   32  ALU result
//  r0_in        in   32  register r0 value
//  r31_in       in   32  register r31 value
//  wcond_in     in   1   write_condition from CPSR stage
//  ovf_clr      in   1   clears sticky overflow
//  tx           out  1   UART line, idle high
//  busy         out  1   high while a frame is being shifted
//  level        out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow     out  1   sticky: a capture was dropped
// BEHAVIOUR
//  Reset (async, reset=0): tx=1, busy=0, level=0, overflow=0, drop_pend=0, FSM IDLE.
//  Capture: capture=1 at edge T with FIFO not full -> entry {flags,pc,alu,r0,r31} written.
//   flags = {6'b0, drop_pend, wcond_in}; drop_pend clears when an entry is accepted.
//  Full: capture while full and no pop that cycle -> dropped, overflow<=1, drop_pend<=1.
//   Push and pop in the same cycle while full -> push accepted, level unchanged.
//  ovf_clr=1 -> overflow<=0 next edge; simultaneous drop wins (overflow stays 1).
//  FSM: IDLE -> LOAD (FIFO non-empty; pop into shift buffer) -> START -> DATA(8 bits,
//   LSB first) -> [PARITY] -> STOP -> next byte START, or IDLE after byte 17.
//  Latency: capture at T into empty FIFO/idle FSM -> pop at T+1, tx falls at T+2.
//  Each bit held exactly CLK_DIV cycles; no idle gap between bytes of a frame; at least
//   one cycle IDLE/LOAD between frames is permitted, no more than one.
//  Frame bytes: 0xA5, flags, pc[31:24..7:0], alu MSB-first, r0 MSB-first, r31 MSB-first.
//  busy=1 from START of byte 0 through end of STOP of byte 17.
//  Baud counter and byte index wrap to 0 at each bit/byte boundary; index never exceeds 17.
//  Reset mid-frame: tx=1 immediately, frame abandoned, FIFO flushed, no resumption.
// CONFIGURATION
//  TRACE_PARITY_EN defined: even parity bit inserted after bit 7 (8E1, 11 bit-times/byte).
//  Not defined: 8N1, 10 bit-times/byte; PARITY state absent.
// STRUCTURE
//  Package trace_pkg: SYNC_BYTE=8'hA5, FRAME_BYTES=18, FSM state typedef, snapshot
//   struct type (flags[7:0], pc, alu, r0, r31 = 136 bits).
//  One sub-module: uart_byte_tx (baud counter + START/DATA/PARITY/STOP shifter,
//   handshake byte_valid/byte_ready). Top holds FIFO, frame sequencer, overflow logic.
// TESTING (bench uses CLK_DIV=4, FIFO_DEPTH=4)
//  1 Reset: hold reset=0 with capture=1 -> tx=1, busy=0, level=0, overflow=0 throughout.
//  2 Single capture pc=0x00000004, alu=0x10, r0=0x1, r31=0xFFFFFFFF, wcond=1 -> tx low
//    at T+2; decoded bytes A5 01 00 00 00 04 00 00 00 10 00 00 00 01 FF FF FF FF;
//    frame lasts 720 cycles (8N1); busy falls after last stop bit.
//  3 capture high 6 consecutive cycles -> level peaks at 4, overflow=1, exactly 5 frames
//    sent; one further capture after drain -> its flags byte = 0x02|wcond.
//  4 TRACE_PARITY_EN: byte 0xA5 -> parity 0, byte 0x01 -> parity 1; frame 792 cycles.
//  5 reset=0 during byte 3 of a frame with 2 entries queued -> tx=1 same cycle,
//    level=0, no further tx activity after release until next capture.
//  6 ovf_clr=1 while overflow=1 and FIFO not full -> overflow=0; ovf_clr with a
//    simultaneous drop -> overflow stays 1.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, types and frame byte selector for trace_uart_tx
// TRACE_PARITY_EN adds the PARITY bit state (8E1 framing).
package trace_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 18;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_LOAD,
    FR_SEND,
    FR_LAST
  } frame_state_t;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
`ifdef TRACE_PARITY_EN
    BIT_PARITY,
`endif
    BIT_STOP
  } bit_state_t;

  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] r0;
    logic [31:0] r31;
  } snapshot_t;

  // Byte 0 is the sync marker; bytes 1..17 walk the snapshot from its MSB down.
  function automatic logic [7:0] frame_byte(input snapshot_t snap, input logic [4:0] idx);
    logic [135:0] v;
    if (idx == 5'd0) return SYNC_BYTE;
    v = snap >> (8 * (FRAME_BYTES - 1 - int'(idx)));
    return v[7:0];
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - single-byte UART shifter with baud counter and valid/ready handshake
// TRACE_PARITY_EN inserts an even parity bit after data bit 7.
module uart_byte_tx
  import trace_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       tx,
  output logic       busy
);

  bit_state_t  state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n;
  logic        bit_end;
`ifdef TRACE_PARITY_EN
  logic        parity, parity_n;
`endif

  assign bit_end    = (baud_cnt == 16'(CLK_DIV - 1));
  assign byte_done  = (state == BIT_STOP) && bit_end;
  // Accepting during the last stop cycle keeps bytes of a frame gap-free.
  assign byte_ready = (state == BIT_IDLE) || byte_done;
  assign busy       = (state != BIT_IDLE);

  always_comb begin
    state_n    = state;
    baud_cnt_n = bit_end ? 16'd0 : baud_cnt + 16'd1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = tx;
`ifdef TRACE_PARITY_EN
    parity_n   = parity;
`endif
    case (state)
      BIT_IDLE: begin
        baud_cnt_n = 16'd0;
        tx_n       = 1'b1;
      end
      BIT_START: if (bit_end) begin
        state_n   = BIT_DATA;
        bit_idx_n = 3'd0;
        tx_n      = shreg[0];
      end
      BIT_DATA: if (bit_end) begin
        shreg_n = {1'b0, shreg[7:1]};
        if (bit_idx == 3'd7) begin
`ifdef TRACE_PARITY_EN
          state_n = BIT_PARITY;
          tx_n    = parity;
`else
          state_n = BIT_STOP;
          tx_n    = 1'b1;
`endif
        end else begin
          bit_idx_n = bit_idx + 3'd1;
          tx_n      = shreg[1];
        end
      end
`ifdef TRACE_PARITY_EN
      BIT_PARITY: if (bit_end) begin
        state_n = BIT_STOP;
        tx_n    = 1'b1;
      end
`endif
      BIT_STOP: if (bit_end) begin
        state_n = BIT_IDLE;
        tx_n    = 1'b1;
      end
      default: state_n = BIT_IDLE;
    endcase
    if (byte_valid && byte_ready) begin
      state_n    = BIT_START;
      baud_cnt_n = 16'd0;
      shreg_n    = byte_data;
      tx_n       = 1'b0;
`ifdef TRACE_PARITY_EN
      parity_n   = ^byte_data;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= BIT_IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      tx       <= 1'b1;
`ifdef TRACE_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
`ifdef TRACE_PARITY_EN
      parity   <= parity_n;
`endif
    end
  end

endmodule

// File: rtl/trace_uart_tx.sv
// rtl/trace_uart_tx.sv - trace snapshot FIFO, 18-byte frame sequencer and overflow tracking
// TRACE_PARITY_EN selects 8E1 framing in uart_byte_tx.
module trace_uart_tx
  import trace_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          capture,
  input  logic [31:0]                   pc_in,
  input  logic [31:0]                   alu_in,
  input  logic [31:0]                   r0_in,
  input  logic [31:0]                   r31_in,
  input  logic                          wcond_in,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [AW:0]    LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]    FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [4:0]     LAST_IDX   = 5'(FRAME_BYTES - 1);

  snapshot_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop, drop;
  logic          drop_pend;
  frame_state_t  state, state_n;
  logic [4:0]    byte_idx, byte_idx_n;
  snapshot_t     snap_buf;
  logic          byte_valid, byte_ready, byte_done;
  logic [7:0]    byte_data;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  // A pop in the same cycle frees the slot, so a capture into a full FIFO still lands.
  assign push  = capture && (!full || pop);
  assign drop  = capture && full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{flags: {6'b0, drop_pend, wcond_in},
                               pc: pc_in, alu: alu_in, r0: r0_in, r31: r31_in};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_pend <= 1'b0;
      overflow  <= 1'b0;
      snap_buf  <= '0;
      state     <= FR_IDLE;
      byte_idx  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        snap_buf <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (push)      drop_pend <= 1'b0;
      else if (drop) drop_pend <= 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      state    <= state_n;
      byte_idx <= byte_idx_n;
    end
  end

  // LAST waits for the final stop bit so frames are separated by exactly one idle cycle.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    pop        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = frame_byte(snap_buf, byte_idx);
    case (state)
      FR_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = FR_LOAD;
      end
      FR_LOAD, FR_SEND: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          if (byte_idx == LAST_IDX) begin
            byte_idx_n = 5'd0;
            state_n    = FR_LAST;
          end else begin
            byte_idx_n = byte_idx + 5'd1;
            state_n    = FR_SEND;
          end
        end
      end
      FR_LAST: if (byte_done) begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = FR_LOAD;
        end else begin
          state_n = FR_IDLE;
        end
      end
      default: state_n = FR_IDLE;
    endcase
  end

  uart_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart (
    .clock      (clock),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_done  (byte_done),
    .tx         (tx),
    .busy       (busy)
  );

endmodule
